// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller: FSM state, per-cycle
// pipeline mode and the bundle of stage enables that each mode produces.
package pipeline_stall_ctrl_pkg;

   localparam int DEF_MAX_STALL = 64;
   // Default counter width; every counter saturates at all-ones of its width.
   localparam int DEF_CNT_W     = 16;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

   typedef enum logic [2:0] {
      MODE_OFF,
      MODE_FREEZE,
      MODE_STALL,
      MODE_FLUSH,
      MODE_FLOW
   } mode_t;

   typedef struct packed {
      logic pc_we;
      logic if_id_we;
      logic if_id_flush;
      logic id_ex_we;
      logic id_ex_bubble;
      logic ex_mem_we;
      logic mem_wb_we;
   } ctrl_t;

   // Watchdog counter must hold MAX_STALL; keep at least one bit when disabled.
   function automatic int consec_width(input int max_stall);
      if (max_stall < 1) return 1;
      return $clog2(max_stall + 1);
   endfunction

   function automatic ctrl_t mode_ctrl(input mode_t mode);
      ctrl_t c;
      c = '0;
      case (mode)
         MODE_STALL: begin
            c.id_ex_bubble = 1'b1;
            c.id_ex_we     = 1'b1;
            c.ex_mem_we    = 1'b1;
            c.mem_wb_we    = 1'b1;
         end
         MODE_FLUSH: begin
            c             = '1;
            c.id_ex_bubble = 1'b0;
         end
         MODE_FLOW: begin
            c              = '1;
            c.if_id_flush  = 1'b0;
            c.id_ex_bubble = 1'b0;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low reset and clear.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] SAT = '1;

   // NOTE: reset is sampled on the clock edge, and all state uses <= so every
   // register in the block sees pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (inc && (count != SAT))
         count <= count + CNT_W'(1);
   end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Hazard stall/flush consumer for the 5-stage core: stage enables, IF/ID
// flush, ID/EX bubble, pending-flush across freezes, watchdog and counters.
module pipeline_stall_ctrl
   import pipeline_stall_ctrl_pkg::*;
#(
   parameter int MAX_STALL = DEF_MAX_STALL,
   parameter int CNT_W     = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall_req,
   input  logic             branch_taken,
   input  logic             mem_busy,
   output logic             pc_we,
   output logic             if_id_we,
   output logic             if_id_flush,
   output logic             id_ex_we,
   output logic             id_ex_bubble,
   output logic             ex_mem_we,
   output logic             mem_wb_we,
   output logic             timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] freeze_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int                   CONSEC_W   = consec_width(MAX_STALL);
   localparam logic [CONSEC_W-1:0]  CONSEC_MAX = CONSEC_W'(MAX_STALL);
   localparam bit                   WD_ENABLE  = (MAX_STALL != 0);

   state_t              state;
   state_t              state_nxt;
   mode_t               mode;
   ctrl_t               ctrl;
   logic                flush_pending;
   logic [CONSEC_W-1:0] consec;
   logic                timeout_q;
   logic                pc_held;
   logic                wd_fire;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= ST_RUN;
      else
         state <= state_nxt;
   end

   // Next-state logic: HALT is only left through reset.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_nxt = state;
      if ((state == ST_RUN) && wd_fire)
         state_nxt = ST_HALT;
   end

   // Output logic: mode priority is freeze > stall > flush > flow.
   always_comb begin
      mode = MODE_OFF;
      if (rst_n && (state == ST_RUN)) begin
         if (mem_busy)
            mode = MODE_FREEZE;
         else if (stall_req)
            mode = MODE_STALL;
         else if (branch_taken || flush_pending)
            mode = MODE_FLUSH;
         else
            mode = MODE_FLOW;
      end
   end

   assign ctrl         = mode_ctrl(mode);
   assign pc_we        = ctrl.pc_we;
   assign if_id_we     = ctrl.if_id_we;
   assign if_id_flush  = ctrl.if_id_flush;
   assign id_ex_we     = ctrl.id_ex_we;
   assign id_ex_bubble = ctrl.id_ex_bubble;
   assign ex_mem_we    = ctrl.ex_mem_we;
   assign mem_wb_we    = ctrl.mem_wb_we;
   assign timeout      = timeout_q;

   // Watchdog trips on the edge where the held-PC run length reaches MAX_STALL.
   assign pc_held = rst_n && (state == ST_RUN) && !ctrl.pc_we;
   assign wd_fire = WD_ENABLE && pc_held && ((consec + CONSEC_W'(1)) == CONSEC_MAX);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         consec    <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (state == ST_RUN) begin
            if (!pc_held)
               consec <= '0;
            else if (consec != CONSEC_MAX)
               consec <= consec + CONSEC_W'(1);
         end
         if (wd_fire)
            timeout_q <= 1'b1;
      end
   end

   // A branch resolved during a freeze is remembered until a flush can issue;
   // a branch alongside stall_req has unresolved operands and is dropped.
   always_ff @(posedge clk) begin
      if (!rst_n)
         flush_pending <= 1'b0;
      else if ((mode == MODE_FREEZE) && branch_taken && !stall_req)
         flush_pending <= 1'b1;
      else if (mode == MODE_FLUSH)
         flush_pending <= 1'b0;
   end

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (1'b0),
      .inc   (mode == MODE_STALL),
      .count (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_freeze_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (1'b0),
      .inc   (mode == MODE_FREEZE),
      .count (freeze_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (1'b0),
      .inc   (mode == MODE_FLUSH),
      .count (flush_cnt)
   );

endmodule
